tim_mch_apb: RTL and testbench

Multi-channel APB timer, the parametrised successor to the single-channel timer_top. It provides NUM_CH independent down-counters of CNT_W bits, each with its own prescaler, periodic or one-shot mode and debug-halt enable. Per-channel status is write-1-to-clear (W1C), masked by an enable register, and combined into one interrupt. It sits on the same zero-wait-state APB slave port as timer_top.

---
 rtl/tim_mch_apb_if.sv | 23 ++
 rtl/tim_mch_apb.sv | 161 ++++++++++++++++
 tb/tb_tim_mch_apb.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tim_mch_apb_if.sv
// APB slave port bundle for the multi-channel timer.
// The master drives the request side; the slave returns data, ready and error.
interface tim_mch_apb_if;
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;

  modport master (
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, tim_pready, tim_pslverr
  );

  modport slave (
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, tim_pready, tim_pslverr
  );
endinterface

// File: rtl/tim_mch_apb.sv
// Multi-channel APB timer: NUM_CH prescaled down-counters with periodic or
// one-shot reload, debug halt, W1C status and a combined masked interrupt.
module tim_mch_apb #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  tim_mch_apb_if.slave      apb,
  input  logic              dbg_mode,
  output logic              tim_int,
  output logic [NUM_CH-1:0] tim_int_ch
);

  logic [NUM_CH-1:0] en_q, mode_q, halt_q;
  logic [NUM_CH-1:0] en_d, mode_d, halt_d;
  logic [3:0]        div_q  [NUM_CH];
  logic [3:0]        div_d  [NUM_CH];
  logic [3:0]        pre_q  [NUM_CH];
  logic [3:0]        pre_d  [NUM_CH];
  logic [CNT_W-1:0]  load_q [NUM_CH];
  logic [CNT_W-1:0]  load_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] int_en_q, int_en_d;
  logic [NUM_CH-1:0] int_sts_q, int_sts_d;
  logic [NUM_CH-1:0] sts_set, sts_clr, run, tick;

  logic        access, err, wr_ok, rd_ok;
  logic        in_ch_space, ch_ok;
  logic        is_ctrl, is_load, is_cnt, is_int_en, is_int_sts, mapped;
  logic [3:0]  ch_idx;
  logic [1:0]  reg_off;
  logic [31:0] wmask, rd_val;
  logic        unused_bits;

  assign access      = apb.tim_psel & apb.tim_penable;
  assign ch_idx      = apb.tim_paddr[7:4];
  assign reg_off     = apb.tim_paddr[3:2];
  assign in_ch_space = (apb.tim_paddr[11:8] == 4'h0);
  assign ch_ok       = in_ch_space && (int'(ch_idx) < NUM_CH);
  assign is_ctrl     = ch_ok && (reg_off == 2'd0);
  assign is_load     = ch_ok && (reg_off == 2'd1);
  assign is_cnt      = ch_ok && (reg_off == 2'd2);
  assign is_int_en   = (apb.tim_paddr[11:2] == 10'h040);
  assign is_int_sts  = (apb.tim_paddr[11:2] == 10'h041);
  assign mapped      = is_ctrl | is_load | is_cnt | is_int_en | is_int_sts;
  assign err         = ~mapped | (apb.tim_pwrite & is_cnt);
  assign wr_ok       = access & apb.tim_pwrite & ~err;
  assign rd_ok       = access & ~apb.tim_pwrite & ~err;

  assign wmask = {{8{apb.tim_pstrb[3]}}, {8{apb.tim_pstrb[2]}},
                  {8{apb.tim_pstrb[1]}}, {8{apb.tim_pstrb[0]}}};
  assign unused_bits = &{1'b0, apb.tim_paddr[1:0], apb.tim_pwdata, wmask};

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ok && (int'(ch_idx) == c)) begin
        case (reg_off)
          2'd0:    rd_val = {20'd0, div_q[c], 5'd0, halt_q[c], mode_q[c], en_q[c]};
          2'd1:    rd_val = 32'(load_q[c]);
          2'd2:    rd_val = 32'(cnt_q[c]);
          default: rd_val = '0;
        endcase
      end
    end
    if (is_int_en)  rd_val = 32'(int_en_q);
    if (is_int_sts) rd_val = 32'(int_sts_q);
  end

  assign apb.tim_prdata  = rd_ok ? rd_val : 32'd0;
  assign apb.tim_pready  = 1'b1;
  assign apb.tim_pslverr = access & err;

  // Counting first, then a CTRL write on the same edge overrides the control bits.
  always_comb begin
    int_en_d = int_en_q;
    sts_set  = '0;
    sts_clr  = '0;
    run      = '0;
    tick     = '0;
    en_d     = en_q;
    mode_d   = mode_q;
    halt_d   = halt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      div_d[c]  = div_q[c];
      pre_d[c]  = pre_q[c];
      load_d[c] = load_q[c];
      cnt_d[c]  = cnt_q[c];

      run[c]  = en_q[c] & ~(halt_q[c] & dbg_mode);
      tick[c] = run[c] & (pre_q[c] == div_q[c]);
      if (run[c]) pre_d[c] = tick[c] ? 4'd0 : pre_q[c] + 4'd1;
      if (tick[c]) begin
        if (cnt_q[c] != '0) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end else begin
          sts_set[c] = 1'b1;
          if (mode_q[c]) en_d[c] = 1'b0;
          else           cnt_d[c] = load_q[c];
        end
      end

      if (wr_ok && is_ctrl && (int'(ch_idx) == c)) begin
        if (apb.tim_pstrb[0]) begin
          en_d[c]   = apb.tim_pwdata[0];
          mode_d[c] = apb.tim_pwdata[1];
          halt_d[c] = apb.tim_pwdata[2];
          if (!en_q[c] && apb.tim_pwdata[0]) begin
            cnt_d[c] = load_q[c];
            pre_d[c] = 4'd0;
          end
        end
        if (apb.tim_pstrb[1]) div_d[c] = apb.tim_pwdata[11:8];
      end

      if (wr_ok && is_load && (int'(ch_idx) == c))
        load_d[c] = (load_q[c] & ~wmask[CNT_W-1:0]) |
                    (apb.tim_pwdata[CNT_W-1:0] & wmask[CNT_W-1:0]);
    end
    if (wr_ok && is_int_en && apb.tim_pstrb[0])
      int_en_d = apb.tim_pwdata[NUM_CH-1:0];
    if (wr_ok && is_int_sts && apb.tim_pstrb[0])
      sts_clr = apb.tim_pwdata[NUM_CH-1:0];
    // A hardware set on the same edge as a clear leaves the bit set.
    int_sts_d = (int_sts_q & ~sts_clr) | sts_set;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_q      <= '0;
      mode_q    <= '0;
      halt_q    <= '0;
      int_en_q  <= '0;
      int_sts_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        div_q[c]  <= '0;
        pre_q[c]  <= '0;
        load_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      halt_q    <= halt_d;
      int_en_q  <= int_en_d;
      int_sts_q <= int_sts_d;
      for (int c = 0; c < NUM_CH; c++) begin
        div_q[c]  <= div_d[c];
        pre_q[c]  <= pre_d[c];
        load_q[c] <= load_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  assign tim_int_ch = int_sts_q & int_en_q;
  assign tim_int    = |tim_int_ch;

endmodule

// File: tb/tb_tim_mch_apb.sv
// Directed bench for tim_mch_apb: a default 4x32 build and a 2x16 build
// sharing clock, reset and dbg_mode, each on its own APB interface.
module tb_tim_mch_apb;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       dbg_mode;
  logic       tim_int0, tim_int1;
  logic [3:0] tim_int_ch0;
  logic [1:0] tim_int_ch1;
  int vectors = 0;
  int miscompares = 0;

  tim_mch_apb_if bus0();
  tim_mch_apb_if bus1();

  tim_mch_apb #(.NUM_CH(4), .CNT_W(32)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(bus0),
    .dbg_mode(dbg_mode), .tim_int(tim_int0), .tim_int_ch(tim_int_ch0)
  );

  tim_mch_apb #(.NUM_CH(2), .CNT_W(16)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(bus1),
    .dbg_mode(dbg_mode), .tim_int(tim_int1), .tim_int_ch(tim_int_ch1)
  );

  always #5 sys_clk = ~sys_clk;

  // Each transfer is exactly two edges; call it 1 time unit after a rising edge.
  task automatic apb_xfer(input int sel, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err);
    if (sel == 0) begin
      bus0.tim_psel = 1'b1; bus0.tim_penable = 1'b0; bus0.tim_pwrite = wr;
      bus0.tim_paddr = addr; bus0.tim_pwdata = wdata; bus0.tim_pstrb = strb;
    end else begin
      bus1.tim_psel = 1'b1; bus1.tim_penable = 1'b0; bus1.tim_pwrite = wr;
      bus1.tim_paddr = addr; bus1.tim_pwdata = wdata; bus1.tim_pstrb = strb;
    end
    @(posedge sys_clk); #1;
    if (sel == 0) bus0.tim_penable = 1'b1;
    else          bus1.tim_penable = 1'b1;
    @(negedge sys_clk);
    rdata = (sel == 0) ? bus0.tim_prdata  : bus1.tim_prdata;
    err   = (sel == 0) ? bus0.tim_pslverr : bus1.tim_pslverr;
    @(posedge sys_clk); #1;
    bus0.tim_psel = 1'b0; bus0.tim_penable = 1'b0;
    bus1.tim_psel = 1'b0; bus1.tim_penable = 1'b0;
  endtask

  task automatic apb_wr(input int sel, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic err);
    logic [31:0] d;
    apb_xfer(sel, 1'b1, addr, data, strb, d, err);
  endtask

  task automatic apb_rd(input int sel, input logic [11:0] addr,
                        output logic [31:0] data, output logic err);
    apb_xfer(sel, 1'b0, addr, 32'd0, 4'h0, data, err);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    sys_rst_n = 1'b0;
    dbg_mode  = 1'b0;
    bus0.tim_psel = 1'b0; bus0.tim_penable = 1'b0; bus0.tim_pwrite = 1'b0;
    bus0.tim_paddr = '0; bus0.tim_pwdata = '0; bus0.tim_pstrb = '0;
    bus1.tim_psel = 1'b0; bus1.tim_penable = 1'b0; bus1.tim_pwrite = 1'b0;
    bus1.tim_paddr = '0; bus1.tim_pwdata = '0; bus1.tim_pstrb = '0;
    #17;
    vectors++;
    if (tim_int0 !== 1'b0 || tim_int_ch0 !== 4'h0 || bus0.tim_pready !== 1'b1 ||
        bus0.tim_prdata !== 32'h0 || bus0.tim_pslverr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got int=%b ch=%h rdy=%b rd=%h err=%b required 0 0 1 0 0",
               tim_int0, tim_int_ch0, bus0.tim_pready, bus0.tim_prdata, bus0.tim_pslverr);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < 3; o++) begin
        apb_rd(0, 12'(c * 16 + o * 4), d, e);
        vectors++;
        if (d !== 32'h0 || e !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL reset_reg ch%0d off%0d: got %h err=%b required 0 err=0", c, o * 4, d, e);
        end
      end
    end
    apb_rd(0, 12'h100, d, e);
    vectors++;
    if (d !== 32'h0 || e !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_int_en: got %h err=%b required 0", d, e);
    end
    apb_rd(0, 12'h104, d, e);
    vectors++;
    if (d !== 32'h0 || e !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_int_sts: got %h err=%b required 0", d, e);
    end
  endtask

  task automatic test_apb_access();
    logic [31:0] d;
    logic e;
    apb_wr(0, 12'h004, 32'h1234_5678, 4'b0011, e);
    apb_rd(0, 12'h004, d, e);
    vectors++;
    if (d !== 32'h0000_5678) begin
      miscompares++; $display("[TB] FAIL load_strobe: got %h required 00005678", d);
    end
    apb_rd(0, 12'h0FC, d, e);
    vectors++;
    if (e !== 1'b1 || d !== 32'h0) begin
      miscompares++; $display("[TB] FAIL unmapped_0fc: got err=%b rd=%h required err=1 rd=0", e, d);
    end
    apb_rd(0, 12'h00C, d, e);
    vectors++;
    if (e !== 1'b1) begin
      miscompares++; $display("[TB] FAIL unmapped_off_c: got err=%b required 1", e);
    end
    apb_rd(0, 12'h040, d, e);
    vectors++;
    if (e !== 1'b1) begin
      miscompares++; $display("[TB] FAIL channel4: got err=%b required 1", e);
    end
    apb_rd(0, 12'h108, d, e);
    vectors++;
    if (e !== 1'b1) begin
      miscompares++; $display("[TB] FAIL unmapped_108: got err=%b required 1", e);
    end
    apb_wr(0, 12'h000, 32'h0000_0F07, 4'b0010, e);
    apb_rd(0, 12'h000, d, e);
    vectors++;
    if (d !== 32'h0000_0F00) begin
      miscompares++; $display("[TB] FAIL ctrl_strobe: got %h required 00000F00", d);
    end
    apb_wr(0, 12'h000, 32'h0, 4'hF, e);
  endtask

  // Leaves channel 0 running so the collision test lands on a known set edge.
  task automatic test_periodic();
    logic [31:0] d;
    logic e;
    apb_wr(0, 12'h004, 32'd3, 4'hF, e);
    apb_wr(0, 12'h100, 32'h1, 4'hF, e);
    apb_wr(0, 12'h000, 32'h1, 4'hF, e);
    for (int k = 1; k <= 8; k++) begin
      @(posedge sys_clk); #1;
      vectors++;
      if (tim_int0 !== (k >= 4)) begin
        miscompares++;
        $display("[TB] FAIL periodic_int edge+%0d: got %b required %b", k, tim_int0, (k >= 4));
      end
    end
    apb_wr(0, 12'h104, 32'h1, 4'h1, e);
    vectors++;
    if (tim_int0 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL w1c_drop: got %b required 0", tim_int0);
    end
    @(posedge sys_clk); #1;
    vectors++;
    if (tim_int0 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL w1c_hold: got %b required 0", tim_int0);
    end
    @(posedge sys_clk); #1;
    vectors++;
    if (tim_int0 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL w1c_reassert: got %b required 1", tim_int0);
    end
    apb_rd(0, 12'h008, d, e);
    vectors++;
    if (d !== 32'd2) begin
      miscompares++; $display("[TB] FAIL periodic_cnt: got %h required 2", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic e;
    apb_wr(0, 12'h104, 32'h1, 4'h1, e);
    vectors++;
    if (tim_int0 !== 1'b1 || tim_int_ch0 !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL set_beats_clear: got int=%b ch=%h required 1 1", tim_int0, tim_int_ch0);
    end
    apb_rd(0, 12'h104, d, e);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++; $display("[TB] FAIL sts_after_collision: got %h required 1", d);
    end
    apb_wr(0, 12'h008, 32'hAA, 4'hF, e);
    vectors++;
    if (e !== 1'b1) begin
      miscompares++; $display("[TB] FAIL cnt_write_err: got %b required 1", e);
    end
    apb_rd(0, 12'h008, d, e);
    vectors++;
    if (d !== 32'd2) begin
      miscompares++; $display("[TB] FAIL cnt_write_ignored: got %h required 2", d);
    end
    apb_wr(0, 12'h000, 32'h0, 4'hF, e);
    apb_wr(0, 12'h104, 32'h1, 4'h1, e);
    vectors++;
    if (tim_int0 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ch0_quiet: got %b required 0", tim_int0);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic e;
    apb_wr(0, 12'h100, 32'hF, 4'hF, e);
    apb_wr(0, 12'h014, 32'd9, 4'hF, e);
    apb_wr(0, 12'h010, 32'h103, 4'hF, e);
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk); #1;
      if (k >= 19) begin
        vectors++;
        if (tim_int_ch0[1] !== (k == 20)) begin
          miscompares++;
          $display("[TB] FAIL oneshot_set edge+%0d: got %b required %b", k, tim_int_ch0[1], (k == 20));
        end
      end
    end
    apb_wr(0, 12'h104, 32'h2, 4'h1, e);
    repeat (50) @(posedge sys_clk);
    #1;
    vectors++;
    if (tim_int_ch0 !== 4'h0) begin
      miscompares++; $display("[TB] FAIL oneshot_no_reset: got %h required 0", tim_int_ch0);
    end
    apb_rd(0, 12'h010, d, e);
    vectors++;
    if (d !== 32'h102) begin
      miscompares++; $display("[TB] FAIL oneshot_ctrl: got %h required 00000102", d);
    end
    apb_rd(0, 12'h018, d, e);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("[TB] FAIL oneshot_cnt: got %h required 0", d);
    end
  endtask

  task automatic test_debug_halt();
    logic [31:0] d;
    logic e;
    apb_wr(0, 12'h024, 32'd100, 4'hF, e);
    apb_wr(0, 12'h034, 32'd100, 4'hF, e);
    apb_wr(0, 12'h020, 32'h5, 4'hF, e);
    apb_wr(0, 12'h030, 32'h1, 4'hF, e);
    dbg_mode = 1'b1;
    apb_rd(0, 12'h028, d, e);
    vectors++;
    if (d !== 32'd98) begin
      miscompares++; $display("[TB] FAIL halt_cnt2_start: got %0d required 98", d);
    end
    apb_rd(0, 12'h038, d, e);
    vectors++;
    if (d !== 32'd97) begin
      miscompares++; $display("[TB] FAIL halt_cnt3_start: got %0d required 97", d);
    end
    repeat (6) @(posedge sys_clk);
    #1;
    apb_rd(0, 12'h028, d, e);
    vectors++;
    if (d !== 32'd98) begin
      miscompares++; $display("[TB] FAIL halt_cnt2_frozen: got %0d required 98", d);
    end
    apb_rd(0, 12'h038, d, e);
    vectors++;
    if (d !== 32'd87) begin
      miscompares++; $display("[TB] FAIL halt_cnt3_running: got %0d required 87", d);
    end
    dbg_mode = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    apb_rd(0, 12'h028, d, e);
    vectors++;
    if (d !== 32'd92) begin
      miscompares++; $display("[TB] FAIL halt_cnt2_resume: got %0d required 92", d);
    end
    apb_wr(0, 12'h020, 32'h0, 4'hF, e);
    apb_wr(0, 12'h030, 32'h0, 4'hF, e);
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    logic e;
    apb_wr(0, 12'h004, 32'd3, 4'hF, e);
    apb_wr(0, 12'h000, 32'h1, 4'hF, e);
    repeat (6) @(posedge sys_clk);
    #1;
    vectors++;
    if (tim_int0 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pre_reset_int: got %b required 1", tim_int0);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if (tim_int0 !== 1'b0 || tim_int_ch0 !== 4'h0) begin
      miscompares++; $display("[TB] FAIL async_reset: got int=%b ch=%h required 0 0", tim_int0, tim_int_ch0);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    apb_rd(0, 12'h000, d, e);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl0: got %h required 0", d);
    end
    apb_rd(0, 12'h004, d, e);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_load0: got %h required 0", d);
    end
    repeat (10) @(posedge sys_clk);
    #1;
    vectors++;
    if (tim_int0 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL no_pending_after_reset: got %b required 0", tim_int0);
    end
  endtask

  task automatic test_small_build();
    logic [31:0] d;
    logic e;
    apb_rd(1, 12'h020, d, e);
    vectors++;
    if (e !== 1'b1 || d !== 32'h0) begin
      miscompares++; $display("[TB] FAIL small_ch2: got err=%b rd=%h required err=1 rd=0", e, d);
    end
    apb_rd(1, 12'h010, d, e);
    vectors++;
    if (e !== 1'b0) begin
      miscompares++; $display("[TB] FAIL small_ch1: got err=%b required 0", e);
    end
    apb_wr(1, 12'h004, 32'hFFFF_FFFF, 4'hF, e);
    apb_rd(1, 12'h004, d, e);
    vectors++;
    if (d !== 32'h0000_FFFF) begin
      miscompares++; $display("[TB] FAIL small_load_width: got %h required 0000FFFF", d);
    end
  endtask

  initial begin
    test_reset();
    test_apb_access();
    test_periodic();
    test_collision();
    test_oneshot();
    test_debug_halt();
    test_reset_midcount();
    test_small_build();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] simulation timeout");
  end
endmodule
